// File: rtl/ship_pkg.sv
// Shared types and helpers for the ship track game controller.
package ship_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      CRASHED  = 2'd2,
      FINISHED = 2'd3
   } ship_state_e;

   localparam int SHIP_LANES     = 8;
   localparam int SHIP_TRACK_LEN = 64;

   // Lane after this cycle's steer pulses; both pulses together cancel out.
   function automatic logic [4:0] steer_lane(input logic [4:0] cur,
                                             input logic       left,
                                             input logic       right,
                                             input logic [4:0] max_lane);
      logic [4:0] nxt;
      nxt = cur;
      if (left && !right && cur != 5'd0)
         nxt = cur - 5'd1;
      else if (right && !left && cur != max_lane)
         nxt = cur + 5'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for a level input; the history register reset value is a parameter.
module rise_edge_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         prev <= RESET_VAL;
      else
         prev <= din;
   end

   assign rise = din & ~prev;

endmodule

// File: rtl/ship_track_ctrl.sv
// Game state machine: owns ship lane and track distance, gates the forward-tick
// generator and checks each advance against the obstacle-map ROM row.
module ship_track_ctrl
   import ship_pkg::*;
#(
   parameter int LANES     = SHIP_LANES,
   parameter int LANE_W    = 3,
   parameter int TRACK_LEN = SHIP_TRACK_LEN,
   parameter int DIST_W    = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              steer_left,
   input  logic              steer_right,
   input  logic              forward_tick,
   input  logic [LANES-1:0]  obstacle_row,
   output logic [DIST_W-1:0] next_row,
   output logic              game_run,
   output logic [LANE_W-1:0] lane,
   output logic [DIST_W-1:0] distance,
   output logic              crash,
   output logic              finish,
   output logic              move_pulse,
   output logic [1:0]        dbg_state
);

   localparam logic [LANE_W-1:0] LANE_HOME = LANE_W'(LANES / 2);
   localparam logic [DIST_W-1:0] LAST_ROW  = DIST_W'(TRACK_LEN - 1);
   localparam logic [4:0]        MAX_LANE  = 5'(LANES - 1);

   ship_state_e       state, state_next;
   logic [LANE_W-1:0] lane_next;
   logic [DIST_W-1:0] dist_next;
   logic              move_next;
   logic              start_rise;
   logic [4:0]        steered_wide;
   logic [LANE_W-1:0] steered;

   // History starts at 1 so a button held through reset release is not a press.
   rise_edge_detect #(.RESET_VAL(1'b1)) u_start_edge (
      .clock (clock),
      .reset (reset),
      .din   (start),
      .rise  (start_rise)
   );

   assign steered_wide = steer_lane(5'(lane), steer_left, steer_right, MAX_LANE);
   assign steered      = steered_wide[LANE_W-1:0];

   always_comb begin
      state_next = state;
      lane_next  = lane;
      dist_next  = distance;
      move_next  = 1'b0;
      case (state)
         IDLE: begin
            lane_next = LANE_HOME;
            dist_next = '0;
            if (start_rise)
               state_next = RUN;
         end
         RUN: begin
            lane_next = steered;
            // Collision is judged in the lane the ship ends up in this cycle.
            if (forward_tick) begin
               if (obstacle_row[steered]) begin
                  state_next = CRASHED;
               end else begin
                  dist_next = distance + DIST_W'(1);
                  move_next = 1'b1;
                  if (dist_next == LAST_ROW)
                     state_next = FINISHED;
               end
            end
         end
         CRASHED, FINISHED: begin
            if (start_rise) begin
               state_next = IDLE;
               lane_next  = LANE_HOME;
               dist_next  = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lane       <= LANE_HOME;
         distance   <= '0;
         move_pulse <= 1'b0;
         game_run   <= 1'b0;
         crash      <= 1'b0;
         finish     <= 1'b0;
      end else begin
         state      <= state_next;
         lane       <= lane_next;
         distance   <= dist_next;
         move_pulse <= move_next;
         game_run   <= (state_next == RUN);
         crash      <= (state_next == CRASHED);
         finish     <= (state_next == FINISHED);
      end
   end

   assign next_row  = (distance >= LAST_ROW) ? LAST_ROW : distance + DIST_W'(1);
   assign dbg_state = state;

endmodule

// File: tb/tb_ship_track_ctrl.sv
// Directed bench for ship_track_ctrl with an 8-lane, 8-row track.
module tb_ship_track_ctrl;
   import ship_pkg::*;

   logic       clock;
   logic       reset;
   logic       start;
   logic       steer_left;
   logic       steer_right;
   logic       forward_tick;
   logic [7:0] obstacle_row;
   logic [2:0] next_row;
   logic       game_run;
   logic [2:0] lane;
   logic [2:0] distance;
   logic       crash;
   logic       finish;
   logic       move_pulse;
   logic [1:0] dbg_state;

   int vectors    = 0;
   int miscompares = 0;

   ship_track_ctrl #(
      .LANES(8), .LANE_W(3), .TRACK_LEN(8), .DIST_W(3)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .steer_left   (steer_left),
      .steer_right  (steer_right),
      .forward_tick (forward_tick),
      .obstacle_row (obstacle_row),
      .next_row     (next_row),
      .game_run     (game_run),
      .lane         (lane),
      .distance     (distance),
      .crash        (crash),
      .finish       (finish),
      .move_pulse   (move_pulse),
      .dbg_state    (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic l, input logic r, input logic t);
      steer_left   = l;
      steer_right  = r;
      forward_tick = t;
      step();
      steer_left   = 1'b0;
      steer_right  = 1'b0;
      forward_tick = 1'b0;
   endtask

   task automatic press_start();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic check_home(input string tag);
      check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
      check({tag, "_lane"}, 32'(lane), 4);
      check({tag, "_dist"}, 32'(distance), 0);
      check({tag, "_run"}, 32'(game_run), 0);
      check({tag, "_crash"}, 32'(crash), 0);
      check({tag, "_finish"}, 32'(finish), 0);
      check({tag, "_move"}, 32'(move_pulse), 0);
      check({tag, "_nrow"}, 32'(next_row), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected end before 100000 ns");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b1;
      steer_left = 1'b0; steer_right = 1'b0; forward_tick = 1'b0;
      obstacle_row = 8'h00;
      #12;
      reset = 1'b0;
      check_home("reset");

      // Held start never looks like a press.
      repeat (3) step();
      check("held_state", 32'(dbg_state), 32'(IDLE));
      check("held_run", 32'(game_run), 0);
      press_start();
      check("start_run", 32'(game_run), 1);
      check("start_state", 32'(dbg_state), 32'(RUN));

      // Steer saturation at both ends and cancelling pulses.
      repeat (5) pulse(1'b0, 1'b1, 1'b0);
      check("sat_right", 32'(lane), 7);
      pulse(1'b1, 1'b1, 1'b0);
      check("both_steer", 32'(lane), 7);
      repeat (8) pulse(1'b1, 1'b0, 1'b0);
      check("sat_left", 32'(lane), 0);
      repeat (4) pulse(1'b0, 1'b1, 1'b0);
      check("back_home", 32'(lane), 4);

      // Clean advance, back-to-back ticks.
      for (int i = 1; i <= 3; i++) begin
         pulse(1'b0, 1'b0, 1'b1);
         check($sformatf("adv%0d_dist", i), 32'(distance), 32'(i));
         check($sformatf("adv%0d_move", i), 32'(move_pulse), 1);
      end
      step();
      check("adv_move_end", 32'(move_pulse), 0);
      check("adv_nrow", 32'(next_row), 4);

      // Obstacle only in lane 5: steering right into it on the tick crashes.
      obstacle_row = 8'b0010_0000;
      pulse(1'b0, 1'b1, 1'b1);
      check("crash_state", 32'(dbg_state), 32'(CRASHED));
      check("crash_lane", 32'(lane), 5);
      check("crash_dist", 32'(distance), 3);
      check("crash_flag", 32'(crash), 1);
      check("crash_run", 32'(game_run), 0);
      check("crash_move", 32'(move_pulse), 0);
      pulse(1'b1, 1'b0, 1'b1);
      check("crash_frozen_lane", 32'(lane), 5);
      check("crash_frozen_dist", 32'(distance), 3);
      obstacle_row = 8'h00;
      press_start();
      check_home("crash_exit");

      // Run to the finish row on an 8-row track.
      press_start();
      check("run2_run", 32'(game_run), 1);
      for (int i = 1; i <= 7; i++) begin
         pulse(1'b0, 1'b0, 1'b1);
         check($sformatf("fin%0d_dist", i), 32'(distance), 32'(i));
      end
      check("fin_flag", 32'(finish), 1);
      check("fin_run", 32'(game_run), 0);
      check("fin_state", 32'(dbg_state), 32'(FINISHED));
      check("fin_nrow", 32'(next_row), 7);
      repeat (2) pulse(1'b0, 1'b0, 1'b1);
      check("fin_frozen_dist", 32'(distance), 7);
      check("fin_frozen_move", 32'(move_pulse), 0);
      press_start();
      check_home("fin_exit");

      // Asynchronous reset between edges.
      press_start();
      repeat (2) pulse(1'b1, 1'b0, 1'b0);
      repeat (5) pulse(1'b0, 1'b0, 1'b1);
      check("mid_dist", 32'(distance), 5);
      check("mid_lane", 32'(lane), 2);
      #2;
      reset = 1'b1;
      #1;
      check_home("async_reset");
      #3;
      reset = 1'b0;
      step();
      check("post_reset_state", 32'(dbg_state), 32'(IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
